// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
// Optional build macro MAIN_CTRL_ADDI_EN adds the addi execute/write-back states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_BRANCH,
    S_JUMP
`ifdef MAIN_CTRL_ADDI_EN
    ,
    S_ADDI_EXEC,
    S_ADDI_WB
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       branch_ne;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  // First state after DECODE; FETCH doubles as the "unsupported opcode" answer.
  function automatic state_e opcode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:    return S_MEM_ADDR;
      OP_RTYPE:        return S_R_EXEC;
      OP_BEQ, OP_BNE:  return S_BRANCH;
      OP_J:            return S_JUMP;
`ifdef MAIN_CTRL_ADDI_EN
      OP_ADDI:         return S_ADDI_EXEC;
`endif
      default:         return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational state -> control-word decoder for the main control FSM.
// Only FETCH looks at mem_ready; DECODE flags unsupported opcodes.
module main_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   op_bne_i,
  input  logic   op_legal_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.ir_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~op_legal_i;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = op_bne_i;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
`ifdef MAIN_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: state register, next-state logic, retire counter.
// Define MAIN_CTRL_ADDI_EN to execute addi; otherwise opcode 001000 is illegal.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic                branch_ne,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALU_op,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] instr_retired
);

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic                op_legal;
  state_e              decode_target;
  ctrl_t               ctrl;

  assign decode_target = opcode_target(opcode);
  assign op_legal      = (decode_target != S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_INIT:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_target;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        // A store retires only once memory accepts it.
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MAIN_CTRL_ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`endif
      default:    state_d = S_INIT;
    endcase
    retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
  end

  main_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .op_bne_i    (opcode == OP_BNE),
    .op_legal_i  (op_legal),
    .ctrl_o      (ctrl)
  );

  assign PCWrite       = ctrl.pc_write;
  assign PCWriteCond   = ctrl.pc_write_cond;
  assign IorD          = ctrl.i_or_d;
  assign MemRead       = ctrl.mem_read;
  assign MemWrite      = ctrl.mem_write;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign IRWrite       = ctrl.ir_write;
  assign RegWrite      = ctrl.reg_write;
  assign RegDst        = ctrl.reg_dst;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign branch_ne     = ctrl.branch_ne;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign PCSource      = ctrl.pc_source;
  assign ALU_op        = ctrl.alu_op;
  assign illegal_op    = ctrl.illegal_op;
  assign instr_retired = retired_q;

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle MIPS main control unit. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath enables, and drives the 2-bit `ALU_op` consumed directly by the downstream ALU control decoder. Sits between the instruction register (opcode source) and the datapath/ALU control, and stalls on a memory ready handshake.

## Interface
Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the next FETCH.
- `mem_ready`  in  1  memory completes the access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  standard datapath controls.
- `branch_ne`  out  1  inverts the zero test for `PCWriteCond` (bne).
- `ALUSrcB`  out  2  ALU B mux select.
- `PCSource`  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target.
- `ALU_op`  out  2  00 add, 01 subtract, 10 funct-decoded.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_retired`  out  `RETIRE_W`  count of completed instructions.

## Operation
States: INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.

Reset:
- Reset enters INIT.
- In INIT, every output is 0 and `instr_retired` is 0.
- INIT always moves to FETCH on the next cycle.

Outputs per state (unlisted outputs are 0):
- FETCH: MemRead=1; ALUSrcB=01; ALU_op=00. PCWrite and IRWrite equal `mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: ALUSrcB=11; ALU_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000000 (R-type) → R_EXEC
  - 000100 (beq) or 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EXEC
  - anything else → FETCH, with `illegal_op` pulsed.
- MEM_ADDR: ALUSrcA=1; ALUSrcB=10; ALU_op=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1; IorD=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: RegWrite=1; MemtoReg=1; RegDst=0. Go to FETCH.
- MEM_WRITE: MemWrite=1; IorD=1. Hold until `mem_ready`, then go to FETCH.
- R_EXEC: ALUSrcA=1; ALUSrcB=00; ALU_op=10. Go to R_WB.
- R_WB: RegDst=1; RegWrite=1. Go to FETCH.
- BRANCH: ALUSrcA=1; ALUSrcB=00; ALU_op=01; PCWriteCond=1; PCSource=01. `branch_ne` = (opcode==000101). Go to FETCH.
- JUMP: PCWrite=1; PCSource=10. Go to FETCH.
- ADDI_EXEC: ALUSrcA=1; ALUSrcB=10; ALU_op=00. Go to ADDI_WB.
- ADDI_WB: RegWrite=1; RegDst=0; MemtoReg=0. Go to FETCH.

Retired counter:
- `instr_retired` increments by 1 in the last cycle of each instruction: MEM_WB, MEM_WRITE with `mem_ready`, R_WB, BRANCH, JUMP, ADDI_WB.
- It wraps modulo 2^`RETIRE_W`.
- Illegal opcodes do not increment it.

## Timing
- Control outputs are Moore decodes of the state register. The only exceptions are the FETCH gating of PCWrite/IRWrite and the MEM_WRITE retire, which are qualified by `mem_ready` in the same cycle.
- Zero-wait cycle counts (FETCH through last state): lw 5, sw 4, R-type 4, beq/bne 3, j 3, addi 4, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. The held state's outputs stay constant throughout.
- `mem_ready` outside the memory states is ignored.
- `rst_n` low mid-instruction immediately forces INIT and zeroes all outputs and the counter. No partial write completes after reset.
- `illegal_op` is high only in the DECODE cycle that detects the illegal opcode.

## Configuration
- `MAIN_CTRL_ADDI_EN` defined: ADDI_EXEC and ADDI_WB exist, and opcode 001000 executes as described above.
- `MAIN_CTRL_ADDI_EN` undefined: both states are removed, and 001000 is treated as illegal (→ FETCH, `illegal_op` pulse, no retire).

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI);
  - ALU_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10).
- One sub-module, `main_ctrl_outdec`: a purely combinational state → control-word decoder.
- The top level holds the state register, next-state logic and the retire counter.

## Test plan
- Reset: hold `rst_n`=0, release → one cycle in INIT with all outputs 0, then FETCH with MemRead=1. With `mem_ready`=1, PCWrite=1 and IRWrite=1 in that same cycle.
- lw, `mem_ready`=1 except 2 wait cycles in MEM_READ → 7 cycles total; MEM_WB asserts RegWrite=1 and MemtoReg=1; `instr_retired` goes 0→1.
- R-type → R_EXEC presents ALU_op=10 and ALUSrcA=1; R_WB has RegDst=1 and RegWrite=1; 4 cycles total.
- bne then beq → BRANCH has ALU_op=01, PCWriteCond=1, PCSource=01; `branch_ne`=1 for bne and 0 for beq; 3 cycles each.
- Opcode 111111 → `illegal_op` high for 1 cycle in DECODE, next state FETCH, `instr_retired` unchanged.
- Opcode 001000 with the macro defined → 4 cycles and retire increment. Without the macro → handled as illegal. Also assert `rst_n` low during MEM_WRITE → MemWrite drops immediately.
